// File: rtl/input_debouncer_pkg.sv
// debounce_pkg: shared defaults and counter sizing for the input debouncer.
// No ports. Exposes DEFAULT_SYNC_STAGES, DEFAULT_STABLE_CYCLES and cnt_width().
package debounce_pkg;
    localparam int DEFAULT_SYNC_STAGES = 2;
    localparam int DEFAULT_STABLE_CYCLES = 4;
    function automatic int cnt_width(input int stable);
        return $clog2(stable + 1);
    endfunction
endpackage

// File: rtl/input_debouncer_if.sv
// input_debouncer_if: bundles raw inputs and conditioned outputs of the debouncer.
// Signals (N_CH bits each): raw (to debouncer), clean, rise, fall, busy (from debouncer).
// master = producer of raw / consumer of results; slave = the debouncer itself.
interface input_debouncer_if #(parameter int N_CH = 1);
    logic [N_CH-1:0] raw;
    logic [N_CH-1:0] clean;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;
    logic [N_CH-1:0] busy;
    modport master (output raw, input clean, rise, fall, busy);
    modport slave (input raw, output clean, rise, fall, busy);
endinterface

// File: rtl/debounce_channel.sv
// debounce_channel: one-bit synchroniser, stability counter, clean level and strobes.
// Ports: clk, rst (sync, active-high); raw (async in); clean (debounced level);
// rise/fall (one-cycle registered strobes); busy (counting a candidate change).
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic clean,
    output logic rise,
    output logic fall,
    output logic busy
);
    localparam int CW = cnt_width(STABLE_CYCLES);

    if (SYNC_STAGES < 2 || STABLE_CYCLES < 1) begin : g_bad_param
        $error("debounce_channel: SYNC_STAGES must be >=2 and STABLE_CYCLES >=1");
    end

    logic [SYNC_STAGES-1:0] s;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic synced;
    logic done;
    logic clean_n;

    assign synced = s[SYNC_STAGES-1];

    // Any sample matching clean clears the count, so a glitch leaves no partial credit.
    always_comb begin
        done = (synced != clean) && (cnt == CW'(STABLE_CYCLES - 1));
        cnt_n = (synced == clean || done) ? '0 : cnt + CW'(1);
        clean_n = done ? synced : clean;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s <= '0;
            cnt <= '0;
            clean <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
            busy <= 1'b0;
        end else begin
            s <= {s[SYNC_STAGES-2:0], raw};
            cnt <= cnt_n;
            clean <= clean_n;
            rise <= clean_n & ~clean;
            fall <= ~clean_n & clean;
            busy <= cnt_n != '0;
        end
    end
endmodule

// File: rtl/input_debouncer.sv
// input_debouncer: N_CH independent debounce channels behind one interface.
// Ports: clk, rst (sync, active-high); bus (input_debouncer_if.slave):
// raw in, clean/rise/fall/busy out, one bit per channel.
module input_debouncer
    import debounce_pkg::*;
#(
    parameter int N_CH = 1,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input logic clk,
    input logic rst,
    input_debouncer_if.slave bus
);
    if (N_CH < 1) begin : g_bad_param
        $error("input_debouncer: N_CH must be >=1");
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES(SYNC_STAGES),
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_ch (
            .clk(clk),
            .rst(rst),
            .raw(bus.raw[i]),
            .clean(bus.clean[i]),
            .rise(bus.rise[i]),
            .fall(bus.fall[i]),
            .busy(bus.busy[i])
        );
    end
endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: self-checking bench for input_debouncer (defaults x3 channels, and a filterless x2 instance).
module tb_input_debouncer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    input_debouncer_if #(.N_CH(3)) if_a();
    input_debouncer_if #(.N_CH(2)) if_b();

    input_debouncer #(.N_CH(3)) u_a (.clk(clk), .rst(rst), .bus(if_a));
    input_debouncer #(.N_CH(2), .SYNC_STAGES(3), .STABLE_CYCLES(1)) u_b (.clk(clk), .rst(rst), .bus(if_b));

    int errors = 0;
    int checks = 0;

    // Reference model: channels 0..2 belong to u_a, 3..4 to u_b.
    bit pipe[5][3];
    bit hist[5][$];
    bit mc[5], mr[5], mf[5], mb[5];

    function automatic int depth(input int ch);
        return ch < 3 ? 2 : 3;
    endfunction

    function automatic int stab(input int ch);
        return ch < 3 ? 4 : 1;
    endfunction

    // clean toggles once the last stab() synced samples all disagree with it.
    task automatic model_edge();
        for (int ch = 0; ch < 5; ch++) begin
            bit r, sy, tog, old;
            r = ch < 3 ? if_a.raw[ch] : if_b.raw[ch-3];
            if (rst) begin
                for (int k = 0; k < 3; k++) pipe[ch][k] = 1'b0;
                hist[ch].delete();
                mc[ch] = 1'b0; mr[ch] = 1'b0; mf[ch] = 1'b0; mb[ch] = 1'b0;
            end else begin
                sy = pipe[ch][depth(ch)-1];
                for (int k = 2; k > 0; k--) pipe[ch][k] = pipe[ch][k-1];
                pipe[ch][0] = r;
                hist[ch].push_back(sy);
                if (hist[ch].size() > 8) void'(hist[ch].pop_front());
                tog = hist[ch].size() >= stab(ch);
                for (int k = 0; k < stab(ch); k++)
                    if (tog && hist[ch][hist[ch].size()-1-k] == mc[ch]) tog = 1'b0;
                old = mc[ch];
                if (tog) mc[ch] = sy;
                mr[ch] = tog && sy;
                mf[ch] = tog && !sy;
                mb[ch] = !tog && (sy != old);
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        logic [2:0] ac, ar, af, ab;
        logic [1:0] bc, br, bf, bb;
        for (int ch = 0; ch < 3; ch++) begin
            ac[ch] = mc[ch]; ar[ch] = mr[ch]; af[ch] = mf[ch]; ab[ch] = mb[ch];
        end
        for (int ch = 0; ch < 2; ch++) begin
            bc[ch] = mc[ch+3]; br[ch] = mr[ch+3]; bf[ch] = mf[ch+3]; bb[ch] = mb[ch+3];
        end
        check("model_a_clean", 32'(if_a.clean), 32'(ac));
        check("model_a_rise", 32'(if_a.rise), 32'(ar));
        check("model_a_fall", 32'(if_a.fall), 32'(af));
        check("model_a_busy", 32'(if_a.busy), 32'(ab));
        check("model_b_clean", 32'(if_b.clean), 32'(bc));
        check("model_b_rise", 32'(if_b.rise), 32'(br));
        check("model_b_fall", 32'(if_b.fall), 32'(bf));
        check("model_b_busy", 32'(if_b.busy), 32'(bb));
        check("a_rise_fall_excl", 32'(if_a.rise & if_a.fall), 32'(0));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        cmp_model();
    endtask

    typedef struct packed {
        logic rst;
        logic raw;
        logic c;
        logic r;
        logic f;
        logic b;
    } vec_t;

    initial begin
        vec_t tv[10];
        logic [9:0] bseq;
        int nr;
        if_a.raw = '0;
        if_b.raw = '0;
        // Reset with raw=1 for two edges, then raw=1 steady on channel 0.
        tv = '{6'b110000, 6'b110000, 6'b010000, 6'b010000, 6'b010001,
               6'b010001, 6'b010001, 6'b011100, 6'b011000, 6'b011000};
        for (int i = 0; i < 10; i++) begin
            rst = tv[i].rst;
            if_a.raw = {2'b00, tv[i].raw};
            step();
            check("tbl_clean", 32'(if_a.clean[0]), 32'(tv[i].c));
            check("tbl_rise", 32'(if_a.rise[0]), 32'(tv[i].r));
            check("tbl_fall", 32'(if_a.fall[0]), 32'(tv[i].f));
            check("tbl_busy", 32'(if_a.busy[0]), 32'(tv[i].b));
        end

        // Short low glitch while clean=1 must be rejected.
        for (int i = 0; i < 9; i++) begin
            if_a.raw[0] = (i >= 3);
            step();
            check("glitch_clean", 32'(if_a.clean[0]), 32'(1));
            check("glitch_strobe", 32'({if_a.rise[0], if_a.fall[0]}), 32'(0));
        end
        check("glitch_busy_end", 32'(if_a.busy[0]), 32'(0));

        // Bounce from clean=0: only the final 4-sample run counts.
        if_a.raw[0] = 1'b0;
        repeat (8) step();
        check("bounce_pre_clean", 32'(if_a.clean[0]), 32'(0));
        bseq = 10'b1111110101;
        nr = 0;
        for (int i = 0; i < 10; i++) begin
            if_a.raw[0] = bseq[i];
            step();
            nr += int'(if_a.rise[0]);
            check("bounce_rise", 32'(if_a.rise[0]), 32'(i == 9));
        end
        repeat (3) begin
            step();
            nr += int'(if_a.rise[0]);
        end
        check("bounce_rise_count", 32'(nr), 32'(1));
        check("bounce_clean", 32'(if_a.clean[0]), 32'(1));

        // Reset in the middle of a count.
        if_a.raw[0] = 1'b0;
        repeat (8) step();
        if_a.raw[0] = 1'b1;
        repeat (3) step();
        check("rst_busy_pre", 32'(if_a.busy[0]), 32'(1));
        rst = 1'b1;
        step();
        check("rst_clean", 32'(if_a.clean[0]), 32'(0));
        check("rst_busy", 32'(if_a.busy[0]), 32'(0));
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
            check("rst_rise", 32'(if_a.rise[0]), 32'(i == 6));
        end

        // Independent channels.
        if_a.raw = 3'b000;
        repeat (8) step();
        if_a.raw = 3'b101;
        for (int i = 0; i < 8; i++) begin
            step();
            check("nch_rise", 32'(if_a.rise), 32'(i == 5 ? 3'b101 : 3'b000));
        end
        if_a.raw = 3'b100;
        for (int i = 0; i < 8; i++) begin
            step();
            check("nch_fall", 32'(if_a.fall), 32'(i == 5 ? 3'b001 : 3'b000));
            check("nch_clean", 32'(if_a.clean), 32'(i >= 5 ? 3'b100 : 3'b101));
        end

        // STABLE_CYCLES=1, SYNC_STAGES=3: a one-cycle pulse passes straight through.
        if_b.raw = 2'b00;
        repeat (4) step();
        for (int i = 0; i < 6; i++) begin
            if_b.raw = {1'b0, i == 0};
            step();
            check("s1_clean", 32'(if_b.clean[0]), 32'(i == 3));
            check("s1_rise", 32'(if_b.rise[0]), 32'(i == 3));
            check("s1_fall", 32'(if_b.fall[0]), 32'(i == 4));
        end

        // Randomised bursts with occasional reset, checked against the model.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) if_a.raw = 3'($urandom);
            if ($urandom_range(0, 2) == 0) if_b.raw = 2'($urandom);
            rst = ($urandom_range(0, 79) == 0);
            step();
        end
        rst = 1'b0;
        repeat (10) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
